rv32i_mem_arbiter: RTL and testbench
====================================

# rv32i_mem_arbiter

Sequencer that shares one single-port memory between the rv32i_top instruction-fetch path and its load/store path. It grants one request at a time, keeps one transaction outstanding, returns the response to the owner, and enforces a response timeout. Data accesses have priority, and a starvation guard stops fetch from being locked out. It sits between rv32i_top and the unified instruction/data memory.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, BUSY cycles allowed without mem_rvalid before an error response (≥2)
- MAX_D_BURST, 2, consecutive data grants allowed while fetch waits (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid (one cycle)
- if_rdata  out  DW  fetch read data
- if_err  out  1  fetch response is a timeout error
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_be  in  DW/8  byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid, d_rdata, d_err  out  1/DW/1  data response; for stores, d_rvalid is the acknowledge
- mem_req  out  1  one-cycle issue pulse to memory
- mem_we, mem_addr, mem_wdata, mem_be  out  1/AW/DW/DW/8  muxed command, valid only while mem_req=1
- mem_rvalid  in  1  memory response or acknowledge
- mem_rdata  in  DW  memory read data

## Operation
- States: IDLE, BUSY_I, BUSY_D. Registered owner, timeout counter tcnt, and streak counter dstreak.
- In IDLE, the winner is chosen combinationally:
  - Only one requester active: that requester wins.
  - Both active: data wins unless dstreak == MAX_D_BURST, in which case fetch wins.
- On a win: winner's gnt=1 and mem_req=1, with mem_* driven from the winner's inputs (fetch forces mem_we=0, mem_be=all ones, mem_wdata=0). Next state is BUSY_I or BUSY_D, and tcnt clears to 0.
- dstreak:
  - +1 on a data grant made while if_req=1 (saturates at MAX_D_BURST).
  - Cleared on a fetch grant, or on a data grant made while if_req=0.
- In BUSY_x, no grants are issued and mem_req=0.
- mem_rvalid=1 in BUSY_x: owner's rvalid=1, rdata=mem_rdata, err=0; next state IDLE.
- No mem_rvalid in BUSY_x: tcnt increments. When tcnt reaches TIMEOUT-1 without mem_rvalid: owner's rvalid=1, err=1, rdata=0; next state IDLE.
- mem_rvalid in the same cycle as the timeout is a normal response (err=0).
- mem_rvalid while IDLE is a stray response and is ignored (no rvalid to either side).
- Non-owner rvalid/err are always 0. rdata outputs are 0 when their rvalid=0.

## Timing
- Reset: all outputs 0, state IDLE, tcnt=0, dstreak=0. Reset takes effect immediately, independent of clk.
- Reset mid-transaction drops the transaction: no response is delivered, and a late mem_rvalid after release is ignored as stray.
- Grant latency: a request seen in IDLE at cycle N gets gnt and mem_req in cycle N (combinational); the state is BUSY from N+1.
- Response latency: mem_rvalid at cycle M gives the owner's rvalid in cycle M (combinational passthrough); the state is IDLE at M+1.
- Earliest next grant is M+1, so back-to-back transactions take at least 2 cycles each (grant cycle + response cycle).
- Timeout: with a grant at cycle N and no mem_rvalid, the error response appears at cycle N+TIMEOUT and IDLE at N+TIMEOUT+1.
- gnt is never asserted outside IDLE. At most one of if_gnt/d_gnt is high, and at most one of if_rvalid/d_rvalid is high.

## Test plan
- Reset: drive rst=1 with requests active -> all outputs 0. Release rst -> first grant on the first IDLE cycle.
- Single fetch: if_addr=0x0000_0004 and memory responds 3 cycles after mem_req with 0x0010_0093 -> if_gnt and mem_req in cycle N with mem_addr=0x4 and mem_we=0; if_rvalid=1 and if_rdata=0x0010_0093 at N+3; if_err=0.
- Priority/starvation, MAX_D_BURST=2: hold if_req and d_req continuously with 1-cycle memory latency -> grant order D, D, I, D, D, I…; no fetch wait exceeds 3 transactions.
- Store: d_we=1, d_addr=0x0000_1000, d_wdata=0xDEAD_BEEF, d_be=4'b0011 -> mem_we=1 and mem_be=0011 carried on the mem_req cycle; d_rvalid on the acknowledge.
- Timeout, TIMEOUT=16: memory never responds -> d_rvalid=1, d_err=1, d_rdata=0 exactly 16 cycles after grant; next grant possible 1 cycle later. Repeat with mem_rvalid in cycle 16 -> err=0 and data passed through.
- Reset mid-op plus stray: assert rst in BUSY_I, release it, then pulse mem_rvalid -> no if_rvalid or d_rvalid; a subsequent fetch completes normally.

Source files
------------

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port memory between the fetch and load/store paths.
// One outstanding transaction, data priority with a fetch starvation guard,
// and a timeout that answers the owner with an error response.
module rv32i_mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 16,
    parameter int MAX_D_BURST = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(MAX_D_BURST + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_BURST);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [SW-1:0] dstreak, dstreak_nxt;

    logic pick_d;
    logic pick_i;
    logic rsp_ok;
    logic rsp_tmo;

    // State, timeout counter and data-streak counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tcnt    <= '0;
            dstreak <= '0;
        end else begin
            state   <= state_nxt;
            tcnt    <= tcnt_nxt;
            dstreak <= dstreak_nxt;
        end
    end

    // Arbitration, memory command mux, response routing and next state
    always_comb begin
        state_nxt   = state;
        tcnt_nxt    = tcnt;
        dstreak_nxt = dstreak;
        if_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        if_err      = 1'b0;
        d_gnt       = 1'b0;
        d_rvalid    = 1'b0;
        d_rdata     = '0;
        d_err       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_be      = '0;

        // Fetch only overtakes data once the streak limit is reached
        pick_d  = d_req && (!if_req || (dstreak != STREAK_MAX));
        pick_i  = if_req && !pick_d;
        rsp_ok  = mem_rvalid;
        rsp_tmo = !mem_rvalid && (tcnt == TCNT_LAST);

        // Outputs are held low during reset even with requests pending
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        d_gnt       = 1'b1;
                        mem_req     = 1'b1;
                        mem_we      = d_we;
                        mem_addr    = d_addr;
                        mem_wdata   = d_wdata;
                        mem_be      = d_be;
                        state_nxt   = BUSY_D;
                        tcnt_nxt    = '0;
                        if (!if_req)
                            dstreak_nxt = '0;
                        else if (dstreak != STREAK_MAX)
                            dstreak_nxt = dstreak + SW'(1);
                    end else if (pick_i) begin
                        if_gnt      = 1'b1;
                        mem_req     = 1'b1;
                        mem_addr    = if_addr;
                        mem_be      = '1;
                        state_nxt   = BUSY_I;
                        tcnt_nxt    = '0;
                        dstreak_nxt = '0;
                    end
                end
                BUSY_I: begin
                    if (rsp_ok || rsp_tmo) begin
                        if_rvalid = 1'b1;
                        if_err    = rsp_tmo;
                        if_rdata  = rsp_ok ? mem_rdata : '0;
                        state_nxt = IDLE;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
                BUSY_D: begin
                    if (rsp_ok || rsp_tmo) begin
                        d_rvalid  = 1'b1;
                        d_err     = rsp_tmo;
                        d_rdata   = rsp_ok ? mem_rdata : '0;
                        state_nxt = IDLE;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: directed scenarios plus a
// randomized run, all compared against a transaction-level reference model.
module tb_rv32i_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 16;
    localparam int MAXD = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt, if_rvalid, if_err;
    logic [DW-1:0]   if_rdata;
    logic            d_req, d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic            d_gnt, d_rvalid, d_err;
    logic [DW-1:0]   d_rdata;
    logic            mem_req, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    rv32i_mem_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(TMO), .MAX_D_BURST(MAXD)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the memory, cycles since its grant,
    // and how many data grants in a row were made while fetch waited.
    int m_owner = 0;     // 0 none, 1 fetch, 2 data
    int m_elapsed = 0;
    int m_streak = 0;
    int cycle_n = 0;
    int resp_at = -1;    // cycle at which the memory model answers

    // Stimulus knobs
    int          lat_fixed = -1;   // -1 random, 0 never, >0 fixed latency
    bit          stray_en = 0;
    bit          rdata_fix_en = 0;
    logic [31:0] rdata_fix = '0;

    // Observations captured from the DUT
    int          rv_cnt = 0;
    int          i_gnt_cyc = -1, d_gnt_cyc = -1, i_rv_cyc = -1, d_rv_cyc = -1;
    logic [31:0] i_rdata_last = '0, d_rdata_last = '0;
    logic        i_err_last = 1'b0, d_err_last = 1'b0;
    logic [68:0] mem_cmd_last = '0;
    byte         gq[$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cycle_n);
        end
    endtask

    task automatic run_cycle();
        logic        e_ig, e_dg, e_mreq, e_we, e_iv, e_dv, e_ie, e_de;
        logic [3:0]  e_be;
        logic [31:0] e_ma, e_mw, e_ir, e_dr;
        logic [69:0] obs_cmd;
        logic        saw_ig, saw_dg;
        int          win, lat;
        @(negedge clk);
        {e_ig, e_dg, e_mreq, e_we, e_iv, e_dv, e_ie, e_de} = '0;
        e_be = '0; e_ma = '0; e_mw = '0; e_ir = '0; e_dr = '0;
        win = 0;
        if (!rst) begin
            if (m_owner == 0) begin
                if (d_req && (!if_req || m_streak < MAXD)) win = 2;
                else if (if_req) win = 1;
                if (win == 2) begin
                    e_dg = 1'b1; e_mreq = 1'b1; e_we = d_we;
                    e_be = d_be; e_ma = d_addr; e_mw = d_wdata;
                end else if (win == 1) begin
                    e_ig = 1'b1; e_mreq = 1'b1; e_be = 4'hf; e_ma = if_addr;
                end
            end else if (mem_rvalid) begin
                if (m_owner == 1) begin e_iv = 1'b1; e_ir = mem_rdata; end
                else begin e_dv = 1'b1; e_dr = mem_rdata; end
            end else if (m_elapsed == TMO) begin
                if (m_owner == 1) begin e_iv = 1'b1; e_ie = 1'b1; end
                else begin e_dv = 1'b1; e_de = 1'b1; end
            end
        end
        obs_cmd = {mem_req, mem_we, mem_be, mem_addr, mem_wdata};
        if (!rst && !mem_req) obs_cmd = {1'b0, 69'b0};
        check("gnt", {if_gnt, d_gnt}, {e_ig, e_dg});
        check("mem_cmd", obs_cmd, {e_mreq, e_we, e_be, e_ma, e_mw});
        check("if_rsp", {if_rvalid, if_err, if_rdata}, {e_iv, e_ie, e_ir});
        check("d_rsp", {d_rvalid, d_err, d_rdata}, {e_dv, e_de, e_dr});

        saw_ig = if_gnt;
        saw_dg = d_gnt;
        if (if_gnt) begin i_gnt_cyc = cycle_n; gq.push_back(8'h49); end
        if (d_gnt) begin d_gnt_cyc = cycle_n; gq.push_back(8'h44); end
        if (mem_req) mem_cmd_last = {mem_we, mem_be, mem_addr, mem_wdata};
        if (if_rvalid) begin
            rv_cnt++; i_rv_cyc = cycle_n; i_rdata_last = if_rdata; i_err_last = if_err;
        end
        if (d_rvalid) begin
            rv_cnt++; d_rv_cyc = cycle_n; d_rdata_last = d_rdata; d_err_last = d_err;
        end

        if (rst) begin
            m_owner = 0; m_streak = 0; m_elapsed = 0; resp_at = -1;
        end else if (m_owner == 0) begin
            if (win != 0) begin
                m_owner = win;
                m_elapsed = 0;
                if (lat_fixed >= 0) lat = lat_fixed;
                else lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
                resp_at = (lat > 0) ? cycle_n + lat : -1;
                if (win == 2 && if_req) m_streak = (m_streak < MAXD) ? m_streak + 1 : MAXD;
                else m_streak = 0;
            end
        end else if (mem_rvalid || m_elapsed == TMO) begin
            m_owner = 0;
            resp_at = -1;
        end
        if (m_owner != 0) m_elapsed++;

        @(posedge clk);
        #1;
        cycle_n++;
        if (saw_ig) if_req = 1'b0;
        if (saw_dg) d_req = 1'b0;
        mem_rvalid = (resp_at >= 0 && resp_at == cycle_n) ||
                     (stray_en && m_owner == 0 && $urandom_range(0, 7) == 0);
        mem_rdata = rdata_fix_en ? rdata_fix : $urandom;
    endtask

    task automatic wait_rsp();
        int c0;
        c0 = rv_cnt;
        for (int k = 0; k < 40; k++) begin
            run_cycle();
            if (rv_cnt != c0) return;
        end
        check("rsp_budget", rv_cnt, c0 + 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (m_owner == 0 && !if_req && !d_req) return;
            run_cycle();
        end
        check("drain_budget", {if_req, d_req, m_owner != 0}, 3'b000);
    endtask

    initial begin
        byte exp_ord[6];
        int  c0;
        exp_ord = '{8'h44, 8'h44, 8'h49, 8'h44, 8'h44, 8'h49};
        rst = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = '0; d_be = 4'hf;
        @(posedge clk); #1;

        // Reset with both requests active, then fixed-priority streak
        run_cycle();
        run_cycle();
        rst = 1'b0;
        lat_fixed = 1;
        gq.delete();
        for (int k = 0; k < 12; k++) begin
            run_cycle();
            if_req = 1'b1;
            d_req = 1'b1;
        end
        for (int i = 0; i < 6; i++) check("grant_order", (i < gq.size()) ? gq[i] : 8'h00, exp_ord[i]);
        if_req = 1'b0; d_req = 1'b0;
        drain();

        // Single fetch, 3-cycle memory latency
        lat_fixed = 3; rdata_fix_en = 1; rdata_fix = 32'h0010_0093;
        if_addr = 32'h4; if_req = 1'b1;
        wait_rsp();
        check("fetch_cmd", mem_cmd_last, {1'b0, 4'hf, 32'h4, 32'h0});
        check("fetch_lat", i_rv_cyc - i_gnt_cyc, 3);
        check("fetch_data", {i_err_last, i_rdata_last}, {1'b0, 32'h0010_0093});

        // Store
        lat_fixed = 2;
        d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011; d_req = 1'b1;
        wait_rsp();
        check("store_cmd", mem_cmd_last, {1'b1, 4'b0011, 32'h1000, 32'hDEAD_BEEF});
        check("store_ack", {d_err_last, d_rv_cyc - d_gnt_cyc}, {1'b0, 32'd2});

        // Timeout, fetch queued behind it
        lat_fixed = 0;
        d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hf; d_req = 1'b1;
        run_cycle();
        if_addr = 32'h8; if_req = 1'b1;
        wait_rsp();
        check("tmo_lat", d_rv_cyc - d_gnt_cyc, TMO);
        check("tmo_rsp", {d_err_last, d_rdata_last}, {1'b1, 32'h0});
        lat_fixed = 1;
        run_cycle();
        check("tmo_regrant", i_gnt_cyc, d_rv_cyc + 1);
        wait_rsp();

        // Response on the last allowed cycle is a normal response
        lat_fixed = TMO; rdata_fix = 32'h1234_5678;
        d_addr = 32'h2004; d_req = 1'b1;
        wait_rsp();
        check("tmo_edge_lat", d_rv_cyc - d_gnt_cyc, TMO);
        check("tmo_edge_rsp", {d_err_last, d_rdata_last}, {1'b0, 32'h1234_5678});

        // Reset while fetch is outstanding, then a stray late response
        lat_fixed = 0;
        if_addr = 32'h10; if_req = 1'b1;
        run_cycle(); run_cycle(); run_cycle();
        c0 = rv_cnt;
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        run_cycle();
        mem_rvalid = 1'b0;
        run_cycle();
        check("stray_ignored", rv_cnt, c0);
        lat_fixed = 2; rdata_fix = 32'hCAFE_F00D;
        if_addr = 32'h14; if_req = 1'b1;
        wait_rsp();
        check("post_reset_fetch", {i_err_last, i_rdata_last, i_rv_cyc - i_gnt_cyc},
              {1'b0, 32'hCAFE_F00D, 32'd2});

        // Randomized traffic with stray responses and occasional resets
        lat_fixed = -1; stray_en = 1; rdata_fix_en = 0;
        for (int k = 0; k < 3000; k++) begin
            run_cycle();
            rst = ($urandom_range(0, 499) == 0);
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom;
                d_wdata = $urandom; d_be = 4'($urandom);
            end
        end
        rst = 1'b0; stray_en = 0;
        if_req = 1'b0; d_req = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
